fetch_stage: RTL and testbench

- Instruction-fetch stage of the pipelined MIPS datapath; sits directly upstream of the instruction memory.
- Owns the program counter and drives the byte address to the instruction memory. The memory returns the big-endian 32-bit word combinationally in the same cycle.
- Captures that word, with PC+4, into the IF/ID pipeline register.
- Handles stall, flush, branch/jump redirect, a halt word and out-of-range fetch.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/if_id_reg.sv | 35 +++
 rtl/fetch_stage.sv | 128 ++++++++++++
 tb/tb_fetch_stage.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding, default words and IF/ID field widths for the fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD_DEF  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD_DEF = 32'hFC00_0000;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register; flush beats hold, hold beats load.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold,
  input  logic               flush,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [PC_W-1:0]    d_pc4,
  input  logic               d_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc4,
  output logic               valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= NOP_WORD;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_WORD;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (!hold) begin
      instr <= d_instr;
      pc4   <= d_pc4;
      valid <= d_valid;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction fetch: PC, BOOT/RUN/HALT FSM, IF/ID capture.
// Optional FETCH_PERF_CNT_EN adds fetch/bubble counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 400,
  parameter logic [31:0] HALT_WORD  = HALT_WORD_DEF,
  parameter logic [31:0] NOP_WORD   = NOP_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] RAdrs,
  input  logic [31:0] ITM,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc4_o,
  output logic        if_id_valid_o,
  output logic        halted_o,
  output logic        fault_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] bubble_cnt_o
`endif
);

  localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_BYTES);

  fetch_state_t state, state_nxt;
  logic [31:0] pc, pc_nxt, pc4, target;
  logic        fault_nxt;
  logic [31:0] d_instr, d_pc4;
  logic        d_valid;
  logic        in_range, capture;

  assign pc4      = pc + 32'd4;
  assign target   = redirect_pc_i & 32'hFFFF_FFFC;
  // 33-bit sum so a PC near the top of the address space cannot wrap into range
  assign in_range = ({1'b0, pc} + 33'd3) < IMEM_LIMIT;
  assign capture  = !stall_i && !flush_i && !redirect_i;
  assign RAdrs    = pc;
  assign halted_o = (state == HALT);
  assign d_pc4    = d_valid ? pc4 : 32'd0;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    fault_nxt = fault_o;
    d_instr   = NOP_WORD;
    d_valid   = 1'b0;
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (in_range) begin
          d_instr = ITM;
          d_valid = 1'b1;
        end
        if (redirect_i) begin
          pc_nxt = target;
        end else if (stall_i) begin
          pc_nxt = pc;
        end else if (capture && !in_range) begin
          fault_nxt = 1'b1;
          state_nxt = HALT;
        end else if (capture && (ITM == HALT_WORD)) begin
          state_nxt = HALT;
        end else begin
          pc_nxt = pc4;
        end
      end
      HALT: begin
        if (redirect_i) begin
          pc_nxt    = target;
          state_nxt = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BOOT;
      pc      <= RESET_PC;
      fault_o <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      fault_o <= fault_nxt;
    end
  end

  if_id_reg #(
    .NOP_WORD(NOP_WORD)
  ) u_if_id (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (stall_i),
    .flush  (flush_i),
    .d_instr(d_instr),
    .d_pc4  (d_pc4),
    .d_valid(d_valid),
    .instr  (if_id_instr_o),
    .pc4    (if_id_pc4_o),
    .valid  (if_id_valid_o)
  );

`ifdef FETCH_PERF_CNT_EN
  logic next_valid;

  assign next_valid = flush_i ? 1'b0 : (stall_i ? if_id_valid_o : d_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (!flush_i && !stall_i && d_valid) fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (!next_valid) bubble_cnt_o <= bubble_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage with a combinational imem model.
module tb_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall_i, flush_i, redirect_i;
  logic [31:0] redirect_pc_i, RAdrs, ITM, if_id_instr_o, if_id_pc4_o;
  logic        if_id_valid_o, halted_o, fault_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_o, bubble_cnt_o;
`endif

  logic [31:0] mem [0:127];
  int checks = 0;
  int errors = 0;

  assign ITM = (RAdrs < 32'd400) ? mem[RAdrs[8:2]] : 32'hDEAD_BEEF;

  fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .RAdrs        (RAdrs),
    .ITM          (ITM),
    .if_id_instr_o(if_id_instr_o),
    .if_id_pc4_o  (if_id_pc4_o),
    .if_id_valid_o(if_id_valid_o),
    .halted_o     (halted_o),
    .fault_o      (fault_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt_o  (fetch_cnt_o),
    .bubble_cnt_o (bubble_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_if(input string tag, input logic [31:0] instr, input logic [31:0] pc4, input logic valid);
    check({tag, "_instr"}, if_id_instr_o, instr);
    check({tag, "_pc4"}, if_id_pc4_o, pc4);
    check({tag, "_valid"}, 32'(if_id_valid_o), 32'(valid));
  endtask

  task automatic expect_reset(input string tag);
    check({tag, "_radrs"}, RAdrs, 32'h0);
    expect_if(tag, 32'h0, 32'h0, 1'b0);
    check({tag, "_halted"}, 32'(halted_o), 32'd0);
    check({tag, "_fault"}, 32'(fault_o), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check({tag, "_fcnt"}, fetch_cnt_o, 32'd0);
    check({tag, "_bcnt"}, bubble_cnt_o, 32'd0);
`endif
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic fl, input logic rd, input logic [31:0] tgt);
    stall_i       = st;
    flush_i       = fl;
    redirect_i    = rd;
    redirect_pc_i = tgt;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = {8'hA0, 8'(i), 16'h1234};
    mem[0] = 32'h2008_0005;
    mem[4] = 32'hFC00_0000;

    rst_n = 1'b0;
    drive(0, 0, 0, 32'h0);
    #12;
    expect_reset("reset");
    rst_n = 1'b1;

    step(1);
    check("boot_valid", 32'(if_id_valid_o), 32'd0);
    check("boot_radrs", RAdrs, 32'h0);
    step(1);
    expect_if("f0", 32'h2008_0005, 32'h4, 1'b1);
    check("f0_radrs", RAdrs, 32'h4);
    step(1);
    expect_if("f1", 32'hA001_1234, 32'h8, 1'b1);
    check("f1_radrs", RAdrs, 32'h8);

    drive(1, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("stall_radrs", RAdrs, 32'h8);
      expect_if("stall", 32'hA001_1234, 32'h8, 1'b1);
    end
    drive(0, 0, 0, 32'h0);
    step(1);
    expect_if("unstall", 32'hA002_1234, 32'hC, 1'b1);

    drive(1, 1, 1, 32'h22);
    step(1);
    check("redir_radrs", RAdrs, 32'h20);
    check("redir_valid", 32'(if_id_valid_o), 32'd0);
    check("redir_instr", if_id_instr_o, 32'h0);
    drive(0, 0, 0, 32'h0);
    step(1);
    expect_if("redir_fetch", 32'hA008_1234, 32'h24, 1'b1);

    drive(0, 1, 1, 32'h10);
    step(1);
    drive(0, 0, 0, 32'h0);
    step(1);
    expect_if("halt", 32'hFC00_0000, 32'h14, 1'b1);
    check("halt_halted", 32'(halted_o), 32'd1);
    check("halt_radrs", RAdrs, 32'h10);
    for (int i = 0; i < 2; i++) begin
      step(1);
      check("halt_bub_valid", 32'(if_id_valid_o), 32'd0);
      check("halt_bub_radrs", RAdrs, 32'h10);
      check("halt_bub_halted", 32'(halted_o), 32'd1);
    end
    drive(0, 0, 1, 32'h0);
    step(1);
    drive(0, 0, 0, 32'h0);
    check("resume_halted", 32'(halted_o), 32'd0);
    check("resume_radrs", RAdrs, 32'h0);
    step(1);
    expect_if("resume", 32'h2008_0005, 32'h4, 1'b1);

    drive(0, 1, 1, 32'h180);
    step(1);
    drive(0, 0, 0, 32'h0);
    step(4);
    expect_if("last_word", 32'hA063_1234, 32'h190, 1'b1);
    check("last_fault", 32'(fault_o), 32'd0);
    step(1);
    check("oor_fault", 32'(fault_o), 32'd1);
    check("oor_halted", 32'(halted_o), 32'd1);
    check("oor_valid", 32'(if_id_valid_o), 32'd0);
    check("oor_radrs", RAdrs, 32'h190);
    step(1);
    check("oor_sticky", 32'(fault_o), 32'd1);
    drive(0, 0, 1, 32'h0);
    step(1);
    drive(0, 0, 0, 32'h0);
    check("oor_redir_halted", 32'(halted_o), 32'd0);
    check("oor_redir_fault", 32'(fault_o), 32'd1);
    step(1);
    expect_if("oor_resume", 32'h2008_0005, 32'h4, 1'b1);

    #2;
    rst_n = 1'b0;
    #1;
    expect_reset("async");

`ifdef FETCH_PERF_CNT_EN
    rst_n = 1'b1;
    step(1);
    check("pc_boot_b", bubble_cnt_o, 32'd1);
    check("pc_boot_f", fetch_cnt_o, 32'd0);
    step(3);
    drive(1, 0, 0, 32'h0);
    step(1);
    drive(0, 1, 1, 32'h20);
    step(1);
    drive(0, 0, 0, 32'h0);
    step(2);
    check("pc_fetch", fetch_cnt_o, 32'd5);
    check("pc_bubble", bubble_cnt_o, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    expect_reset("pc_async");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
